// File: rtl/flit_rx_monitor_if.sv
// Flit stream bundle between a router crossbar output mux (master) and a receive monitor (slave).
interface flit_rx_monitor_if #(
    parameter int unsigned DATAW = 66,
    parameter int unsigned VCHW  = 2
);
    logic [DATAW-1:0] idata;
    logic             ivalid;
    logic [VCHW-1:0]  ivch;

    modport master (output idata, output ivalid, output ivch);
    modport slave  (input  idata, input  ivalid, input  ivch);
endinterface

// File: rtl/flit_rx_monitor.sv
// Receive-side flit stream monitor: HEAD/DATA/TAIL framing checks plus packet, flit, cycle and toggle statistics.
// Optional length check on TAIL is built only when MON_LEN_CHECK_EN is defined.
module flit_rx_monitor #(
    parameter int unsigned DATAW = 66,
    parameter int unsigned VCHW  = 2,
    parameter int unsigned CNTW  = 32,
    parameter int unsigned TGLW  = 40
`ifdef MON_LEN_CHECK_EN
    ,
    parameter int unsigned EXP_LEN = 20
`endif
) (
    input  logic                    clk,
    input  logic                    rst_,
    flit_rx_monitor_if.slave        flit,
    input  logic                    en,
    input  logic                    clr,
    output logic                    busy,
    output logic [CNTW-1:0]         pkt_cnt,
    output logic [CNTW-1:0]         flit_cnt,
    output logic [CNTW-1:0]         cyc_cnt,
    output logic [7:0]              last_len,
    output logic [TGLW-1:0]         tgl_acc,
    output logic                    err_frame,
    output logic                    err_vch,
    output logic                    err_len
);

    localparam int unsigned POPW = $clog2(DATAW + 1);

    typedef enum logic [1:0] {
        T_NONE = 2'b00,
        T_HEAD = 2'b01,
        T_TAIL = 2'b10,
        T_DATA = 2'b11
    } flit_type_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BODY = 1'b1
    } state_e;

    logic [DATAW-1:0] idata;
    logic             ivalid;
    logic [VCHW-1:0]  ivch;
    flit_type_e       ftype;

    assign idata  = flit.idata;
    assign ivalid = flit.ivalid;
    assign ivch   = flit.ivch;
    assign ftype  = flit_type_e'(idata[DATAW-1 -: 2]);

    state_e           state_q,     state_d;
    logic [7:0]       len_q,       len_d;
    logic [VCHW-1:0]  cur_vch_q,   cur_vch_d;
    logic [DATAW-1:0] prev_idata_q, prev_idata_d;
    logic [CNTW-1:0]  pkt_cnt_q,   pkt_cnt_d;
    logic [CNTW-1:0]  flit_cnt_q,  flit_cnt_d;
    logic [CNTW-1:0]  cyc_cnt_q,   cyc_cnt_d;
    logic [7:0]       last_len_q,  last_len_d;
    logic [TGLW-1:0]  tgl_acc_q,   tgl_acc_d;
    logic             err_frame_q, err_frame_d;
    logic             err_vch_q,   err_vch_d;

    logic             frame_evt;
    logic             vch_evt;
    logic             tail_evt;
    logic [POPW-1:0]  pop;
    logic [TGLW:0]    tgl_sum;

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        return (&v) ? v : v + CNTW'(1);
    endfunction

    // Framing FSM: only valid flits move it; idle cycles hold state, len and cur_vch.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cur_vch_d = cur_vch_q;
        frame_evt = 1'b0;
        vch_evt   = 1'b0;
        tail_evt  = 1'b0;
        if (ivalid) begin
            case (state_q)
                S_IDLE: begin
                    if (ftype == T_HEAD) begin
                        state_d   = S_BODY;
                        len_d     = '0;
                        cur_vch_d = ivch;
                    end else begin
                        frame_evt = 1'b1;
                    end
                end
                S_BODY: begin
                    vch_evt = (ivch != cur_vch_q);
                    case (ftype)
                        T_DATA: begin
                            if (len_q != '1) begin
                                len_d = len_q + 8'd1;
                            end
                        end
                        T_TAIL: begin
                            tail_evt = 1'b1;
                            state_d  = S_IDLE;
                        end
                        T_HEAD: begin
                            frame_evt = 1'b1;
                            len_d     = '0;
                            cur_vch_d = ivch;
                        end
                        T_NONE: begin
                            frame_evt = 1'b1;
                            state_d   = S_IDLE;
                        end
                        default: ;
                    endcase
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        pop     = POPW'($countones(idata ^ prev_idata_q));
        tgl_sum = {1'b0, tgl_acc_q} + (TGLW + 1)'(pop);
    end

    // Statistics and sticky flags; clr overrides en and any same-cycle event.
    always_comb begin
        prev_idata_d = idata;
        pkt_cnt_d    = pkt_cnt_q;
        flit_cnt_d   = flit_cnt_q;
        cyc_cnt_d    = cyc_cnt_q;
        last_len_d   = last_len_q;
        tgl_acc_d    = tgl_acc_q;
        err_frame_d  = err_frame_q;
        err_vch_d    = err_vch_q;
        if (clr) begin
            pkt_cnt_d   = '0;
            flit_cnt_d  = '0;
            cyc_cnt_d   = '0;
            last_len_d  = '0;
            tgl_acc_d   = '0;
            err_frame_d = 1'b0;
            err_vch_d   = 1'b0;
        end else begin
            if (en) begin
                cyc_cnt_d = sat_inc(cyc_cnt_q);
                tgl_acc_d = tgl_sum[TGLW] ? '1 : tgl_sum[TGLW-1:0];
                if (ivalid) begin
                    flit_cnt_d = sat_inc(flit_cnt_q);
                end
                if (tail_evt) begin
                    pkt_cnt_d = sat_inc(pkt_cnt_q);
                end
            end
            if (tail_evt) begin
                last_len_d = len_q;
            end
            err_frame_d = err_frame_q | frame_evt;
            err_vch_d   = err_vch_q | vch_evt;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            cur_vch_q    <= '0;
            prev_idata_q <= '0;
            pkt_cnt_q    <= '0;
            flit_cnt_q   <= '0;
            cyc_cnt_q    <= '0;
            last_len_q   <= '0;
            tgl_acc_q    <= '0;
            err_frame_q  <= 1'b0;
            err_vch_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            cur_vch_q    <= cur_vch_d;
            prev_idata_q <= prev_idata_d;
            pkt_cnt_q    <= pkt_cnt_d;
            flit_cnt_q   <= flit_cnt_d;
            cyc_cnt_q    <= cyc_cnt_d;
            last_len_q   <= last_len_d;
            tgl_acc_q    <= tgl_acc_d;
            err_frame_q  <= err_frame_d;
            err_vch_q    <= err_vch_d;
        end
    end

`ifdef MON_LEN_CHECK_EN
    logic err_len_q, err_len_d;

    always_comb begin
        err_len_d = err_len_q;
        if (clr) begin
            err_len_d = 1'b0;
        end else if (tail_evt && (len_q != 8'(EXP_LEN))) begin
            err_len_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            err_len_q <= 1'b0;
        end else begin
            err_len_q <= err_len_d;
        end
    end

    assign err_len = err_len_q;
`else
    assign err_len = 1'b0;
`endif

    assign busy      = (state_q == S_BODY);
    assign pkt_cnt   = pkt_cnt_q;
    assign flit_cnt  = flit_cnt_q;
    assign cyc_cnt   = cyc_cnt_q;
    assign last_len  = last_len_q;
    assign tgl_acc   = tgl_acc_q;
    assign err_frame = err_frame_q;
    assign err_vch   = err_vch_q;

endmodule

// File: tb/tb_flit_rx_monitor.sv
// Self-checking bench for flit_rx_monitor: vector table, directed corner sequences and a random run against a packet-level model.
module tb_flit_rx_monitor;

    localparam logic [1:0] TN = 2'b00;
    localparam logic [1:0] TH = 2'b01;
    localparam logic [1:0] TT = 2'b10;
    localparam logic [1:0] TD = 2'b11;
    localparam longint CMAX = 64'h0000_0000_FFFF_FFFF;
    localparam longint TMAX = 64'h0000_00FF_FFFF_FFFF;

    logic        clk;
    logic        rst_;
    logic        en;
    logic        clr;
    logic        busy;
    logic [31:0] pkt_cnt;
    logic [31:0] flit_cnt;
    logic [31:0] cyc_cnt;
    logic [7:0]  last_len;
    logic [39:0] tgl_acc;
    logic        err_frame;
    logic        err_vch;
    logic        err_len;

    int checks = 0;
    int errors = 0;

    flit_rx_monitor_if #(.DATAW(66), .VCHW(2)) fif ();

    flit_rx_monitor #(.DATAW(66), .VCHW(2), .CNTW(32), .TGLW(40)) dut (
        .clk       (clk),
        .rst_      (rst_),
        .flit      (fif),
        .en        (en),
        .clr       (clr),
        .busy      (busy),
        .pkt_cnt   (pkt_cnt),
        .flit_cnt  (flit_cnt),
        .cyc_cnt   (cyc_cnt),
        .last_len  (last_len),
        .tgl_acc   (tgl_acc),
        .err_frame (err_frame),
        .err_vch   (err_vch),
        .err_len   (err_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Packet-level reference model
    bit          m_open;
    int          m_len;
    int          m_vch;
    logic [65:0] m_prev;
    longint      m_pkt, m_flit, m_cyc, m_tgl;
    int          m_last;
    bit          m_ef, m_ev, m_el;

    function automatic longint sat_add(input longint v, input longint inc, input longint mx);
        return (v + inc > mx) ? mx : v + inc;
    endfunction

    task automatic model_reset();
        m_open = 0; m_len = 0; m_vch = 0; m_prev = '0;
        m_pkt = 0; m_flit = 0; m_cyc = 0; m_tgl = 0; m_last = 0;
        m_ef = 0; m_ev = 0; m_el = 0;
    endtask

    task automatic model_step(input logic [65:0] d, input bit v, input logic [1:0] c,
                              input bit e, input bit cl);
        int pop;
        bit frame, vche, tail, lerr;
        logic [1:0] ty;
        pop = 0;
        for (int unsigned i = 0; i < 66; i++) if (d[i] != m_prev[i]) pop++;
        ty = d[65:64];
        frame = 0; vche = 0; tail = 0; lerr = 0;
        if (v) begin
            if (!m_open) begin
                if (ty == TH) begin m_open = 1; m_len = 0; m_vch = int'(c); end
                else frame = 1;
            end else begin
                vche = (int'(c) != m_vch);
                case (ty)
                    TD: m_len = (m_len < 255) ? m_len + 1 : 255;
                    TT: begin tail = 1; m_open = 0; lerr = (m_len != 20); end
                    TH: begin frame = 1; m_len = 0; m_vch = int'(c); end
                    default: begin frame = 1; m_open = 0; end
                endcase
            end
        end
        if (cl) begin
            m_pkt = 0; m_flit = 0; m_cyc = 0; m_tgl = 0; m_last = 0;
            m_ef = 0; m_ev = 0; m_el = 0;
        end else begin
            if (tail) m_last = m_len;
            if (e) begin
                m_cyc = sat_add(m_cyc, 1, CMAX);
                m_tgl = sat_add(m_tgl, pop, TMAX);
                if (v) m_flit = sat_add(m_flit, 1, CMAX);
                if (tail) m_pkt = sat_add(m_pkt, 1, CMAX);
            end
            m_ef = m_ef | frame;
            m_ev = m_ev | vche;
`ifdef MON_LEN_CHECK_EN
            m_el = m_el | lerr;
`endif
        end
        m_prev = d;
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".busy"},      longint'(busy),      longint'(m_open));
        chk({tag, ".pkt_cnt"},   longint'(pkt_cnt),   m_pkt);
        chk({tag, ".flit_cnt"},  longint'(flit_cnt),  m_flit);
        chk({tag, ".cyc_cnt"},   longint'(cyc_cnt),   m_cyc);
        chk({tag, ".last_len"},  longint'(last_len),  longint'(m_last));
        chk({tag, ".tgl_acc"},   longint'(tgl_acc),   m_tgl);
        chk({tag, ".err_frame"}, longint'(err_frame), longint'(m_ef));
        chk({tag, ".err_vch"},   longint'(err_vch),   longint'(m_ev));
        chk({tag, ".err_len"},   longint'(err_len),   longint'(m_el));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".busy"},      longint'(busy),      0);
        chk({tag, ".pkt_cnt"},   longint'(pkt_cnt),   0);
        chk({tag, ".flit_cnt"},  longint'(flit_cnt),  0);
        chk({tag, ".cyc_cnt"},   longint'(cyc_cnt),   0);
        chk({tag, ".last_len"},  longint'(last_len),  0);
        chk({tag, ".tgl_acc"},   longint'(tgl_acc),   0);
        chk({tag, ".err_frame"}, longint'(err_frame), 0);
        chk({tag, ".err_vch"},   longint'(err_vch),   0);
        chk({tag, ".err_len"},   longint'(err_len),   0);
    endtask

    function automatic logic [65:0] mk(input logic [1:0] ty, input logic [63:0] pl);
        return {ty, pl};
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic cycle(input string tag, input logic [65:0] d, input bit v, input logic [1:0] c,
                         input bit e, input bit cl);
        fif.idata  = d;
        fif.ivalid = v;
        fif.ivch   = c;
        en         = e;
        clr        = cl;
        @(posedge clk);
        model_step(d, v, c, e, cl);
        #1;
        check_model(tag);
    endtask

    task automatic do_reset();
        rst_ = 1'b0;
        fif.idata = mk(2'($urandom), rnd64());
        fif.ivalid = 1'b1;
        fif.ivch = 2'($urandom);
        en = 1'b1;
        clr = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        check_zero("in_reset");
        rst_ = 1'b1;
        fif.ivalid = 1'b0;
        #1;
        check_zero("post_reset");
    endtask

    typedef struct {
        bit         valid;
        logic [1:0] ty;
        logic [1:0] vch;
        bit         en;
        bit         clr;
        bit         busy;
        int         pkt;
        int         last;
        bit         ef;
        bit         ev;
    } vec_t;

    vec_t tbl[19];

    initial begin
        rst_ = 1'b0; en = 1'b0; clr = 1'b0;
        fif.idata = '0; fif.ivalid = 1'b0; fif.ivch = '0;

        //            valid ty  vch en clr  busy pkt last ef ev
        tbl[0]  = '{1, TD, 2'd0, 1, 0,   0, 0, 0, 1, 0};
        tbl[1]  = '{0, TN, 2'd0, 1, 1,   0, 0, 0, 0, 0};
        tbl[2]  = '{1, TH, 2'd0, 1, 0,   1, 0, 0, 0, 0};
        tbl[3]  = '{1, TD, 2'd2, 1, 0,   1, 0, 0, 0, 1};
        tbl[4]  = '{1, TT, 2'd0, 1, 0,   0, 1, 1, 0, 1};
        tbl[5]  = '{0, TN, 2'd0, 1, 1,   0, 0, 0, 0, 0};
        tbl[6]  = '{1, TH, 2'd1, 1, 0,   1, 0, 0, 0, 0};
        tbl[7]  = '{1, TD, 2'd1, 1, 0,   1, 0, 0, 0, 0};
        tbl[8]  = '{1, TH, 2'd1, 1, 0,   1, 0, 0, 1, 0};
        tbl[9]  = '{1, TT, 2'd1, 1, 0,   0, 1, 0, 1, 0};
        tbl[10] = '{1, TN, 2'd1, 1, 0,   0, 1, 0, 1, 0};
        tbl[11] = '{0, TN, 2'd1, 1, 1,   0, 0, 0, 0, 0};
        tbl[12] = '{1, TH, 2'd3, 1, 0,   1, 0, 0, 0, 0};
        tbl[13] = '{1, TN, 2'd3, 1, 0,   0, 0, 0, 1, 0};
        tbl[14] = '{1, TT, 2'd3, 1, 1,   0, 0, 0, 0, 0};
        tbl[15] = '{1, TT, 2'd3, 0, 0,   0, 0, 0, 1, 0};
        tbl[16] = '{1, TH, 2'd2, 0, 0,   1, 0, 0, 1, 0};
        tbl[17] = '{1, TD, 2'd2, 0, 0,   1, 0, 0, 1, 0};
        tbl[18] = '{1, TT, 2'd2, 0, 0,   0, 0, 1, 1, 0};

        // Reset and nominal 20-DATA packet
        do_reset();
        cycle("nom_head", mk(TH, rnd64()), 1, 2'd1, 1, 0);
        for (int i = 0; i < 20; i++) cycle("nom_data", mk(TD, rnd64()), 1, 2'd1, 1, 0);
        cycle("nom_tail", mk(TT, rnd64()), 1, 2'd1, 1, 0);
        for (int i = 0; i < 7; i++) cycle("nom_idle", mk(TN, rnd64()), 0, 2'd1, 1, 0);
        chk("nom.pkt_cnt",   longint'(pkt_cnt),   1);
        chk("nom.flit_cnt",  longint'(flit_cnt),  22);
        chk("nom.cyc_cnt",   longint'(cyc_cnt),   29);
        chk("nom.last_len",  longint'(last_len),  20);
        chk("nom.err_frame", longint'(err_frame), 0);
        chk("nom.err_vch",   longint'(err_vch),   0);
        chk("nom.err_len",   longint'(err_len),   0);

        // Vector table
        do_reset();
        for (int unsigned i = 0; i < 19; i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            cycle(t, mk(tbl[i].ty, 64'd0), tbl[i].valid, tbl[i].vch, tbl[i].en, tbl[i].clr);
            chk({t, ".busy"},      longint'(busy),      longint'(tbl[i].busy));
            chk({t, ".pkt_cnt"},   longint'(pkt_cnt),   longint'(tbl[i].pkt));
            chk({t, ".last_len"},  longint'(last_len),  longint'(tbl[i].last));
            chk({t, ".err_frame"}, longint'(err_frame), longint'(tbl[i].ef));
            chk({t, ".err_vch"},   longint'(err_vch),   longint'(tbl[i].ev));
        end

        // Toggle accumulation and clear retaining prev_idata
        do_reset();
        cycle("tgl0", '0, 0, 2'd0, 1, 0);
        cycle("tgl1", '1, 0, 2'd0, 1, 0);
        cycle("tgl2", '1, 0, 2'd0, 1, 0);
        cycle("tgl3", '0, 0, 2'd0, 1, 0);
        chk("tgl.acc132", longint'(tgl_acc), 132);
        cycle("tgl_clr", '1, 0, 2'd0, 1, 1);
        chk("tgl.clr", longint'(tgl_acc), 0);
        cycle("tgl_keep", '1, 0, 2'd0, 1, 0);
        chk("tgl.prev_kept", longint'(tgl_acc), 0);
        cycle("tgl_back", '0, 0, 2'd0, 1, 0);
        chk("tgl.after", longint'(tgl_acc), 66);

        // Short packet length check and len saturation
        do_reset();
        cycle("l19_head", mk(TH, rnd64()), 1, 2'd0, 1, 0);
        for (int i = 0; i < 19; i++) cycle("l19_data", mk(TD, rnd64()), 1, 2'd0, 1, 0);
        cycle("l19_tail", mk(TT, rnd64()), 1, 2'd0, 1, 0);
        chk("l19.last_len", longint'(last_len), 19);
`ifdef MON_LEN_CHECK_EN
        chk("l19.err_len", longint'(err_len), 1);
`else
        chk("l19.err_len", longint'(err_len), 0);
`endif
        cycle("l260_head", mk(TH, rnd64()), 1, 2'd2, 1, 1);
        for (int i = 0; i < 260; i++) cycle("l260_data", mk(TD, rnd64()), 1, 2'd2, 1, 0);
        cycle("l260_tail", mk(TT, rnd64()), 1, 2'd2, 1, 0);
        chk("l260.last_len", longint'(last_len), 255);

        // Reset asserted mid-packet
        do_reset();
        cycle("mid_head", mk(TH, rnd64()), 1, 2'd1, 1, 0);
        for (int i = 0; i < 5; i++) cycle("mid_data", mk(TD, rnd64()), 1, 2'd1, 1, 0);
        chk("mid.busy_before", longint'(busy), 1);
        #2;
        rst_ = 1'b0;
        model_reset();
        #1;
        chk("mid.busy_in_reset", longint'(busy), 0);
        check_zero("mid_reset");
        rst_ = 1'b1;
        cycle("mid_after", mk(TD, rnd64()), 1, 2'd1, 1, 0);
        chk("mid.err_frame", longint'(err_frame), 1);
        chk("mid.busy_after", longint'(busy), 0);

        // Random traffic against the model
        do_reset();
        for (int unsigned n = 0; n < 3000; n++) begin
            logic [1:0] ty;
            logic [1:0] c;
            bit v, e, cl;
            int r;
            v = ($urandom_range(0, 99) < 80);
            r = $urandom_range(0, 99);
            if (m_open) ty = (r < 70) ? TD : (r < 85) ? TT : (r < 93) ? TH : TN;
            else        ty = (r < 70) ? TH : (r < 80) ? TD : (r < 90) ? TT : TN;
            c  = ($urandom_range(0, 99) < 90) ? 2'(m_vch) : 2'($urandom);
            e  = ($urandom_range(0, 99) < 90);
            cl = ($urandom_range(0, 99) < 3);
            cycle("rnd", mk(ty, rnd64()), v, c, e, cl);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/flit_rx_monitor.md
Name: flit_rx_monitor

Overview:
- Receive-side endpoint for the single-output flit stream (odata/ovalid/ovch) produced by the router crossbar muxes.
- Parses HEAD/DATA/TAIL framing and checks packet integrity.
- Accumulates the statistics the energy-characterization flow needs: packet and flit counts, link utilization, and per-cycle bit-toggle (Hamming) activity on the data wires.

Parameters:
- DATAW, 66, flit width; type field in bits [DATAW-1:DATAW-2], payload in the remaining 64 bits.
- VCHW, 2, virtual-channel id width.
- CNTW, 32, width of the packet, flit and cycle counters.
- TGLW, 40, width of the toggle accumulator.
- T_NONE / T_HEAD / T_TAIL / T_DATA, 2'b00 / 2'b01 / 2'b10 / 2'b11, flit type encodings.
- EXP_LEN, 20, expected DATA flits per packet; used only with the optional feature.

Ports:
- clk  in  1  clock, rising edge
- rst_  in  1  asynchronous active-low reset
- idata  in  DATAW  flit from mux odata
- ivalid  in  1  flit valid
- ivch  in  VCHW  virtual channel of flit
- en  in  1  statistics enable; counters advance only while high
- clr  in  1  synchronous clear of counters and error flags; has priority over en
- busy  out  1  high while a packet is open (state BODY)
- pkt_cnt  out  CNTW  completed packets
- flit_cnt  out  CNTW  valid flits accepted
- cyc_cnt  out  CNTW  cycles with en=1
- last_len  out  8  DATA-flit count of the most recent completed packet
- tgl_acc  out  TGLW  accumulated popcount(idata ^ prev_idata)
- err_frame  out  1  sticky framing error
- err_vch  out  1  sticky VC-change-within-packet error
- err_len  out  1  sticky length-mismatch error; optional feature only

Behaviour:
- Reset (rst_=0, asynchronous):
  - State IDLE.
  - All outputs 0.
  - Internal prev_idata=0, len=0, cur_vch=0.
- All outputs are registered. Effects appear 1 cycle after the sampling edge.
- FSM states: IDLE, BODY. Transitions occur on ivalid=1 only; ivalid=0 cycles hold state, len and cur_vch.
- IDLE:
  - HEAD: go to BODY, len=0, cur_vch=ivch.
  - DATA or TAIL: set err_frame, stay in IDLE.
  - NONE with ivalid=1: set err_frame.
- BODY:
  - DATA: len+1. len saturates at 255.
  - TAIL: pkt_cnt+1 (if en), last_len=len, go to IDLE.
  - HEAD: set err_frame, restart the packet (len=0, cur_vch=ivch), stay in BODY.
  - NONE: set err_frame, go to IDLE.
  - Any valid flit with ivch!=cur_vch: set err_vch. The flit is still processed by type.
- flit_cnt increments on every valid flit while en=1, including erroneous flits.
- cyc_cnt increments every cycle while en=1.
- Utilization = flit_cnt/cyc_cnt, computed by software.
- Toggle activity:
  - Every cycle, prev_idata <= idata, regardless of ivalid and en.
  - While en=1, tgl_acc += popcount(idata ^ prev_idata). The popcount spans all DATAW bits, 0..66.
  - The first cycle after reset compares against 0.
- Saturation: all counters and tgl_acc saturate at all-ones; they never wrap.
- clr=1:
  - Zeroes pkt_cnt, flit_cnt, cyc_cnt, tgl_acc, last_len and all err_* flags.
  - Does not change the FSM state, len or prev_idata.
  - clr and en high together: clear wins for that cycle.
- en=0: the FSM and error detection still run. Only the counters freeze; pkt_cnt also freezes.
- Reset asserted mid-packet: immediate return to IDLE. A following DATA flit raises err_frame.

Optional Feature:
- Macro MON_LEN_CHECK_EN.
- Defined: on TAIL in BODY, if len != EXP_LEN, set err_len (sticky, cleared by clr/reset).
- Undefined: err_len is constant 0 and no compare logic is built.

Test Plan:
- Reset: hold rst_=0 with random idata, then release -> all outputs 0, busy=0.
- Nominal packet: en=1; HEAD, 20 DATA, TAIL on vch 1, then 7 idle cycles -> pkt_cnt=1, flit_cnt=22, cyc_cnt=29, last_len=20, no errors; err_len=0 with MON_LEN_CHECK_EN.
- Framing: DATA flit while IDLE -> err_frame=1 next cycle, busy=0. HEAD, then HEAD -> err_frame=1, busy=1, len restarts.
- VC change: HEAD on vch 0, DATA on vch 2 -> err_vch=1. TAIL then completes the packet: pkt_cnt=1, last_len=1.
- Toggles: idata 0 -> all-ones -> all-ones -> 0 over 3 cycles with en=1 -> tgl_acc=132; clr=1 -> tgl_acc=0 while prev_idata is retained.
- Length and reset: with MON_LEN_CHECK_EN, a packet of 19 DATA -> err_len=1. Reset asserted after 5 DATA -> busy=0, next DATA -> err_frame=1.
